dlf_acq_sequencer: RTL and testbench

//  Acquisition/lock sequencer for the PLL digital PI loop filter (13-bit ctrl word, Kp/Ki/Kf).
//  - Holds the filter in reset until enabled.
//  - Runs frequency acquisition by gating frequency-detector pulses onto the filter's fup/fdn.
//  - Then runs phase acquisition and tracking, selecting a gain gear per phase.
//  - Reports lock. Sits between the PFD/FD front end and the loop filter.

---
 rtl/dlf_acq_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_dlf_acq_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dlf_acq_sequencer.sv
//==============================================================================
// Module      : dlf_acq_sequencer
// Description : Acquisition/lock sequencer for the PLL digital PI loop filter.
//               Steps IDLE -> FACQ -> PACQ -> TRACK, gates FD pulses onto the
//               filter's fup/fdn, selects the gain gear and reports lock.
//               Optional macro LOSS_OF_LOCK_EN enables loss-of-lock exit from TRACK.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dlf_acq_sequencer #(
    parameter int FD_QUIET    = 256,
    parameter int PD_TH       = 1,
    parameter int LOCK_CNT    = 512,
    parameter int ACQ_TIMEOUT = 4096,
    parameter int UNLOCK_CNT  = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic signed [3:0] pd_in,
    input  logic              fd_up,
    input  logic              fd_dn,
    output logic              fup,
    output logic              fdn,
    output logic              lf_reset,
    output logic [1:0]        gear,
    output logic              locked,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FACQ  = 2'd1,
        S_PACQ  = 2'd2,
        S_TRACK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_QUIET_LAST = CNT_W'(FD_QUIET - 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST  = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(ACQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [4:0]       c_PD_TH      = 5'(PD_TH);

    generate
        if (FD_QUIET < 1 || LOCK_CNT < 1 || ACQ_TIMEOUT < 1 || UNLOCK_CNT < 1 || CNT_W < 2) begin : g_param_check
            $error("dlf_acq_sequencer: thresholds must be >= 1 and CNT_W >= 2");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_quiet_cnt, w_quiet_nxt, w_quiet_inc;
    logic [CNT_W-1:0] r_lock_cnt,  w_lock_nxt,  w_lock_inc;
    logic [CNT_W-1:0] r_tmo_cnt,   w_tmo_nxt,   w_tmo_inc;
    logic             r_fup, r_fdn, r_lf_reset, r_locked;
    logic [1:0]       r_gear;
    logic             w_fup_nxt, w_fdn_nxt, w_lf_reset_nxt, w_locked_nxt;
    logic [1:0]       w_gear_nxt;
    logic [4:0]       w_pd_ext, w_pd_abs;
    logic             w_fd_pulse, w_phase_quiet;

    // Sign-extend to 5 bits first so that -8 yields +8 rather than wrapping.
    assign w_pd_ext      = {pd_in[3], pd_in};
    assign w_pd_abs      = pd_in[3] ? (5'd0 - w_pd_ext) : w_pd_ext;
    assign w_phase_quiet = (w_pd_abs <= c_PD_TH);
    assign w_fd_pulse    = fd_up | fd_dn;

    assign w_quiet_inc = (&r_quiet_cnt) ? r_quiet_cnt : r_quiet_cnt + c_ONE;
    assign w_lock_inc  = (&r_lock_cnt)  ? r_lock_cnt  : r_lock_cnt  + c_ONE;
    assign w_tmo_inc   = (&r_tmo_cnt)   ? r_tmo_cnt   : r_tmo_cnt   + c_ONE;

`ifdef LOSS_OF_LOCK_EN
    localparam logic [CNT_W-1:0] c_BAD_LAST = CNT_W'(UNLOCK_CNT - 1);
    logic [CNT_W-1:0] r_bad_cnt, w_bad_nxt, w_bad_inc;
    assign w_bad_inc = (&r_bad_cnt) ? r_bad_cnt : r_bad_cnt + c_ONE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_quiet_nxt = r_quiet_cnt;
        w_lock_nxt  = r_lock_cnt;
        w_tmo_nxt   = r_tmo_cnt;
        w_fup_nxt   = 1'b0;
        w_fdn_nxt   = 1'b0;
`ifdef LOSS_OF_LOCK_EN
        w_bad_nxt   = r_bad_cnt;
`endif
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_quiet_nxt = '0;
            w_lock_nxt  = '0;
            w_tmo_nxt   = '0;
`ifdef LOSS_OF_LOCK_EN
            w_bad_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FACQ;
                    w_quiet_nxt = '0;
                end
                S_FACQ: begin
                    w_fup_nxt = fd_up & ~fd_dn;
                    w_fdn_nxt = fd_dn & ~fd_up;
                    if (w_fd_pulse) begin
                        w_quiet_nxt = '0;
                    end else if (r_quiet_cnt == c_QUIET_LAST) begin
                        w_state_nxt = S_PACQ;
                        w_quiet_nxt = '0;
                        w_lock_nxt  = '0;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_quiet_nxt = w_quiet_inc;
                    end
                end
                S_PACQ: begin
                    // Lock is tested before timeout so a coincident pair resolves to lock.
                    if (w_fd_pulse || (!(w_phase_quiet && r_lock_cnt == c_LOCK_LAST) &&
                                       r_tmo_cnt == c_TMO_LAST)) begin
                        w_state_nxt = S_FACQ;
                        w_quiet_nxt = '0;
                        w_lock_nxt  = '0;
                        w_tmo_nxt   = '0;
                    end else if (w_phase_quiet && r_lock_cnt == c_LOCK_LAST) begin
                        w_state_nxt = S_TRACK;
                        w_lock_nxt  = '0;
                        w_tmo_nxt   = '0;
`ifdef LOSS_OF_LOCK_EN
                        w_bad_nxt   = '0;
`endif
                    end else begin
                        w_lock_nxt = w_phase_quiet ? w_lock_inc : '0;
                        w_tmo_nxt  = w_tmo_inc;
                    end
                end
                S_TRACK: begin
`ifdef LOSS_OF_LOCK_EN
                    if (w_fd_pulse || (!w_phase_quiet && r_bad_cnt == c_BAD_LAST)) begin
                        w_state_nxt = S_FACQ;
                        w_quiet_nxt = '0;
                        w_lock_nxt  = '0;
                        w_tmo_nxt   = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_bad_nxt = w_phase_quiet ? '0 : w_bad_inc;
                    end
`endif
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_lf_reset_nxt = (w_state_nxt == S_IDLE);
        w_locked_nxt   = (w_state_nxt == S_TRACK);
        case (w_state_nxt)
            S_FACQ:  w_gear_nxt = 2'd2;
            S_PACQ:  w_gear_nxt = 2'd1;
            default: w_gear_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_quiet_cnt <= '0;
            r_lock_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_fup       <= 1'b0;
            r_fdn       <= 1'b0;
            r_lf_reset  <= 1'b1;
            r_gear      <= 2'd0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_quiet_cnt <= w_quiet_nxt;
            r_lock_cnt  <= w_lock_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_fup       <= w_fup_nxt;
            r_fdn       <= w_fdn_nxt;
            r_lf_reset  <= w_lf_reset_nxt;
            r_gear      <= w_gear_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

`ifdef LOSS_OF_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bad_cnt <= '0;
        end else begin
            r_bad_cnt <= w_bad_nxt;
        end
    end
`endif

    assign fup      = r_fup;
    assign fdn      = r_fdn;
    assign lf_reset = r_lf_reset;
    assign gear     = r_gear;
    assign locked   = r_locked;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_dlf_acq_sequencer.sv
//==============================================================================
// Module      : tb_dlf_acq_sequencer
// Description : Directed self-checking bench for dlf_acq_sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dlf_acq_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic signed [3:0] pd_in;
    logic              fd_up;
    logic              fd_dn;
    logic              fup;
    logic              fdn;
    logic              lf_reset;
    logic [1:0]        gear;
    logic              locked;
    logic [1:0]        state;
    logic [7:0]        obs;

    int n_vec = 0;
    int n_err = 0;

    // {state, gear, lf_reset, locked, fup, fdn}
    localparam logic [7:0] c_IDLE  = 8'b00_00_1_0_0_0;
    localparam logic [7:0] c_FACQ  = 8'b01_10_0_0_0_0;
    localparam logic [7:0] c_FUP   = 8'b01_10_0_0_1_0;
    localparam logic [7:0] c_FDN   = 8'b01_10_0_0_0_1;
    localparam logic [7:0] c_PACQ  = 8'b10_01_0_0_0_0;
    localparam logic [7:0] c_TRACK = 8'b11_00_0_1_0_0;

    assign obs = {state, gear, lf_reset, locked, fup, fdn};

    always #5 clk = ~clk;

    dlf_acq_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .pd_in    (pd_in),
        .fd_up    (fd_up),
        .fd_dn    (fd_dn),
        .fup      (fup),
        .fdn      (fdn),
        .lf_reset (lf_reset),
        .gear     (gear),
        .locked   (locked),
        .state    (state)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; fd_up = 1'b0; fd_dn = 1'b0; pd_in = 4'sd0;
        #2;
        n_vec++;
        if (obs !== c_IDLE) begin n_err++; $display("FAIL reset_async: got %b want %b", obs, c_IDLE); end
        tick(2);
        reset = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_IDLE) begin n_err++; $display("FAIL reset_idle_en0: got %b want %b", obs, c_IDLE); end
    endtask

    task automatic test_lock_sequence();
        en = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL seq_facq_entry: got %b want %b", obs, c_FACQ); end
        tick(255);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL seq_facq_255: got %b want %b", obs, c_FACQ); end
        tick(1);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL seq_pacq_256: got %b want %b", obs, c_PACQ); end
        tick(511);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL seq_pacq_511: got %b want %b", obs, c_PACQ); end
        tick(1);
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL seq_track_512: got %b want %b", obs, c_TRACK); end
    endtask

    task automatic test_fd_gating();
        en = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_IDLE) begin n_err++; $display("FAIL gate_idle: got %b want %b", obs, c_IDLE); end
        en = 1'b1;
        tick(9);
        fd_up = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_FUP) begin n_err++; $display("FAIL gate_fup_on: got %b want %b", obs, c_FUP); end
        fd_up = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL gate_fup_off: got %b want %b", obs, c_FACQ); end
        fd_up = 1'b1; fd_dn = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL gate_both: got %b want %b", obs, c_FACQ); end
        fd_up = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_FDN) begin n_err++; $display("FAIL gate_fdn_on: got %b want %b", obs, c_FDN); end
        fd_dn = 1'b0;
        tick(255);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL gate_quiet_restart_255: got %b want %b", obs, c_FACQ); end
        tick(1);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL gate_quiet_restart_256: got %b want %b", obs, c_PACQ); end
    endtask

    task automatic test_pacq_timeout();
        for (int i = 0; i < 4095; i++) begin
            pd_in = (i % 2 == 1) ? 4'sd3 : 4'sd0;
            tick(1);
        end
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL tmo_pacq_4095: got %b want %b", obs, c_PACQ); end
        pd_in = 4'sd0;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL tmo_facq_4096: got %b want %b", obs, c_FACQ); end
    endtask

    task automatic test_pacq_noise_and_fd();
        tick(256);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL noise_pacq_entry: got %b want %b", obs, c_PACQ); end
        pd_in = -4'sd8;
        tick(600);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL noise_neg8_nolock: got %b want %b", obs, c_PACQ); end
        fd_dn = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL noise_fd_exit: got %b want %b", obs, c_FACQ); end
        fd_dn = 1'b0;
        pd_in = -4'sd1;
        tick(256);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL edge_pacq_entry: got %b want %b", obs, c_PACQ); end
        tick(511);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL edge_neg1_511: got %b want %b", obs, c_PACQ); end
        tick(1);
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL edge_neg1_lock: got %b want %b", obs, c_TRACK); end
    endtask

    task automatic test_track();
        pd_in = 4'sd4;
        tick(63);
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL track_noisy_63: got %b want %b", obs, c_TRACK); end
        tick(1);
`ifdef LOSS_OF_LOCK_EN
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL track_unlock_64: got %b want %b", obs, c_FACQ); end
`else
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL track_absorb_64: got %b want %b", obs, c_TRACK); end
        fd_up = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL track_ignore_fd: got %b want %b", obs, c_TRACK); end
        fd_up = 1'b0;
`endif
        pd_in = 4'sd0;
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(257);
        n_vec++;
        if (obs !== c_PACQ) begin n_err++; $display("FAIL endrop_pacq: got %b want %b", obs, c_PACQ); end
        tick(100);
        en = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_IDLE) begin n_err++; $display("FAIL endrop_idle: got %b want %b", obs, c_IDLE); end
        en = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL endrop_refacq: got %b want %b", obs, c_FACQ); end
        tick(256 + 512);
        n_vec++;
        if (obs !== c_TRACK) begin n_err++; $display("FAIL endrop_relock: got %b want %b", obs, c_TRACK); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== c_IDLE) begin n_err++; $display("FAIL areset_midtrack: got %b want %b", obs, c_IDLE); end
        tick(1);
        reset = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== c_FACQ) begin n_err++; $display("FAIL areset_restart: got %b want %b", obs, c_FACQ); end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_fd_gating();
        test_pacq_timeout();
        test_pacq_noise_and_fd();
        test_track();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
